// File: rtl/load_use_hazard_unit.sv
// Load-use hazard control for the accumulator pipeline: stalls PC/IF-ID and
// bubbles ID/EX on unresolvable load-use, flushes on taken branch, keeps stats.
module load_use_hazard_unit #(
    parameter int          LOAD_LATENCY = 1,
    parameter int          CNT_W        = 16,
    parameter logic [5:0]  NOP_OPCODE   = 6'h00
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [5:0]       iOpcode_ID,
    input  logic             iReadsA_ID,
    input  logic             iReadsB_ID,
    input  logic             iWritesA_ID,
    input  logic             iWritesB_ID,
    input  logic             iIsLoad_ID,
    input  logic             iBranchTaken_EX,
    output logic             oPC_Enable,
    output logic             oIFID_Enable,
    output logic             oIDEX_Bubble,
    output logic             oIFID_Flush,
    output logic             oStalled,
    output logic [CNT_W-1:0] oStallCount,
    output logic [CNT_W-1:0] oFlushCount
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0]       CNT_LOAD = 2'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_n;
    logic [1:0]       cnt, cnt_n;
    logic             ex_load_a, ex_load_b;
    logic             hz, stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_count, flush_count;

    assign hz = (iOpcode_ID != NOP_OPCODE) &
                ((ex_load_a & iReadsA_ID) | (ex_load_b & iReadsB_ID));

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        oPC_Enable   = 1'b1;
        oIFID_Enable = 1'b1;
        oIDEX_Bubble = 1'b0;
        oIFID_Flush  = 1'b0;
        oStalled     = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!Reset) begin
            oPC_Enable   = 1'b0;
            oIFID_Enable = 1'b0;
            oIDEX_Bubble = 1'b1;
        end else if (iBranchTaken_EX) begin
            // branch target must load, so enables stay high while both stages flush
            oIFID_Flush  = 1'b1;
            oIDEX_Bubble = 1'b1;
            flush_inc    = 1'b1;
            state_n      = RUN;
            cnt_n        = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz) begin
                        oPC_Enable   = 1'b0;
                        oIFID_Enable = 1'b0;
                        oIDEX_Bubble = 1'b1;
                        oStalled     = 1'b1;
                        stall_inc    = 1'b1;
                        cnt_n        = CNT_LOAD;
                        state_n      = (LOAD_LATENCY > 1) ? STALL : RUN;
                    end
                end
                STALL: begin
                    oPC_Enable   = 1'b0;
                    oIFID_Enable = 1'b0;
                    oIDEX_Bubble = 1'b1;
                    oStalled     = 1'b1;
                    stall_inc    = 1'b1;
                    // cnt counts the stall cycles still owed, this one included
                    cnt_n        = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                    if (cnt <= 2'd1) state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= RUN;
            cnt         <= 2'd0;
            ex_load_a   <= 1'b0;
            ex_load_b   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ex_load_a <= !oIDEX_Bubble & iIsLoad_ID & iWritesA_ID;
            ex_load_b <= !oIDEX_Bubble & iIsLoad_ID & iWritesB_ID;
            if (stall_inc && stall_count != '1) stall_count <= stall_count + ONE;
            if (flush_inc && flush_count != '1) flush_count <= flush_count + ONE;
        end
    end

    assign oStallCount = stall_count;
    assign oFlushCount = flush_count;

endmodule
